board_renderer: RTL
===================

# board_renderer

Pixel-pipeline stage directly downstream of the VGA timing generator. Consumes its X/Y pixel coordinates and HS/VS/BLANK_N strobes and produces the RGB colour for an 8×8 game board. Game logic updates a double-buffered cell store, which is swapped atomically at vertical sync so the display never tears. Outputs drive the DE2-115 VGA DAC pins together with delay-matched sync signals.

## Interface
- BOARD_N, 8: cells per side.
- CELL_PX, 48: cell edge length in pixels.
- BOARD_X0, 128: left pixel column of the board.
- BOARD_Y0, 48: top pixel row of the board.
- DISC_R, 18: disc radius in pixels.
- CLK_50  in  1  system clock. Single clock domain.
- RST_N  in  1  asynchronous active-low reset.
- PIX_EN  in  1  pixel-clock enable, one CLK_50 cycle per pixel. All pipeline stages advance only when it is high.
- X, Y  in  11 each  active pixel coordinate from the timing generator.
- IN_HS, IN_VS, IN_BLANK_N  in  1 each  timing strobes.
- WR_EN  in  1  write the shadow cell selected by WR_ROW/WR_COL.
- WR_ROW, WR_COL  in  3 each  cell address.
- WR_DATA  in  2  cell state (cell_t).
- COMMIT  in  1  one-cycle request to publish the shadow store.
- COMMIT_DONE  out  1  one-cycle pulse when the publish happens.
- CUR_ROW, CUR_COL  in  3 each  cursor cell.
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour.
- VGA_HS, VGA_VS, VGA_BLANK_N  out  1 each  delay-matched strobes.

## Operation
- **Cell states (cell_t):** EMPTY=0, P1=1, P2=2, MARK=3.
- **Stores:** two BOARD_N×BOARD_N arrays of cell_t, the shadow and the display. Reset clears both to EMPTY.
- **Writes:** WR_EN writes the shadow on any CLK_50 edge, independent of PIX_EN. If WR_ROW ≥ BOARD_N or WR_COL ≥ BOARD_N, the write is dropped.
- **Commit:**
  - COMMIT sets `pending`.
  - A VS falling edge is IN_VS sampled 1→0 on a PIX_EN cycle.
  - On a VS falling edge with `pending`=1: copy the whole shadow to the display in one cycle, clear `pending`, and pulse COMMIT_DONE.
  - Repeated COMMITs before the edge collapse into one publish.
  - COMMIT on the same cycle as the edge is published at that edge.
  - A write on the copy cycle lands in the shadow only. The copy uses the pre-write value.
- **Stage 1:**
  - Compute `inside` = BOARD_X0 ≤ X < BOARD_X0+BOARD_N·CELL_PX, and likewise for Y.
  - Column = count of thresholds BOARD_X0+k·CELL_PX ≤ X for k=1..BOARD_N-1. No divider. Row is computed the same way from Y.
  - Compute offsets ox, oy in 0..CELL_PX-1.
- **Stage 2:**
  - Read the display cell.
  - dx = ox−CELL_PX/2 and dy = oy−CELL_PX/2, signed 7-bit.
  - d2 = dx²+dy², unsigned 13-bit.
  - grid = (ox==0)||(oy==0)||(ox==CELL_PX-1)||(oy==CELL_PX-1).
- **Stage 3 colour priority:**
  1. !inside → BG (0,0,64).
  2. grid → LINE (0,0,0).
  3. cursor hit → CURSOR (255,255,0).
  4. d2 < DISC_R² with P1 → (255,0,0), P2 → (255,255,255), MARK → (0,255,0).
  5. Otherwise BOARD (0,128,0).
- **Blanking:** when the delayed BLANK_N is 0, RGB is forced to 0.

## Timing
- Latency is 3 PIX_EN cycles from X/Y to VGA_R/G/B.
- IN_HS, IN_VS and IN_BLANK_N pass through a matching 3-stage PIX_EN shift so colour and strobes stay aligned.
- Reset values: VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, COMMIT_DONE=0, `pending`=0. The pipeline registers clear to the same values.
- Reset mid-frame: outputs return to reset values immediately (asynchronous). The output follows the input timing again 3 PIX_EN cycles after release.
- With PIX_EN=0, all pipeline registers and the VS edge detector hold their values.

## Configuration
- BOARD_CURSOR_EN defined: a cursor outline is drawn in the cell matching CUR_ROW/CUR_COL. The outline covers the 2-pixel band where 1 ≤ ox,oy ≤ 2 or CELL_PX-3 ≤ ox,oy ≤ CELL_PX-2.
- BOARD_CURSOR_EN undefined: cursor logic is removed. CUR_ROW/CUR_COL remain as ports and are ignored.

## Structure
- board_pkg holds:
  - the cell_t enum;
  - the RGB colour constants BG, LINE, CURSOR, P1_C, P2_C, MARK_C, BOARD_C;
  - the pipeline depth constant PIPE_DEPTH=3.
- board_store is the single natural sub-module. It contains the shadow/display arrays, the write port, `pending`, commit-on-VS logic and the combinational read port. board_renderer holds the pipeline.

## Test plan
- **Reset:** RST_N low mid-line → RGB=0, HS=VS=1, BLANK_N=0 within the same cycle.
- **Write then commit:** write (2,3)=P1, pulse COMMIT, run to VS fall → COMMIT_DONE pulses once. Pixel X=128+3·48+24=296, Y=48+2·48+24=168 renders (255,0,0) 3 PIX_EN cycles later.
- **No commit:** write (0,0)=P2 without COMMIT → pixel (152,72) stays BOARD (0,128,0) across 2 frames.
- **Geometry:** X=128,Y=100 → LINE. X=127 → BG. X=511 → LINE. X=512 → BG. Y during blank → RGB 0.
- **Dropped write:** WR_ROW=7 with BOARD_N=7 is dropped. Also, a write on the copy cycle is not visible until the next commit.
- **Cursor:** with BOARD_CURSOR_EN, CUR=(4,4), pixel (128+4·48+1, 48+4·48+10) → (255,255,0). Without the macro, the same pixel → BOARD colour.

Source files
------------

// File: rtl/board_pkg.sv
// Shared types and geometry for the board renderer: cell states, colours, pipeline depth.
// Board geometry is fixed here so the renderer and its store agree on sizes.
package board_pkg;

  localparam int BOARD_N    = 8;
  localparam int CELL_PX    = 48;
  localparam int BOARD_X0   = 128;
  localparam int BOARD_Y0   = 48;
  localparam int DISC_R     = 18;
  localparam int PIPE_DEPTH = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    P1    = 2'd1,
    P2    = 2'd2,
    MARK  = 2'd3
  } cell_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t BG      = '{r: 8'd0,   g: 8'd0,   b: 8'd64};
  localparam rgb_t LINE    = '{r: 8'd0,   g: 8'd0,   b: 8'd0};
  localparam rgb_t CURSOR  = '{r: 8'd255, g: 8'd255, b: 8'd0};
  localparam rgb_t P1_C    = '{r: 8'd255, g: 8'd0,   b: 8'd0};
  localparam rgb_t P2_C    = '{r: 8'd255, g: 8'd255, b: 8'd255};
  localparam rgb_t MARK_C  = '{r: 8'd0,   g: 8'd255, b: 8'd0};
  localparam rgb_t BOARD_C = '{r: 8'd0,   g: 8'd128, b: 8'd0};

  // Cell index by counting crossed cell boundaries; a comparator chain instead of a divider.
  function automatic logic [2:0] cell_index(input logic [10:0] pos, input logic [10:0] origin);
    logic [2:0] idx;
    idx = '0;
    for (int k = 1; k < BOARD_N; k++) begin
      if (pos >= origin + 11'(k * CELL_PX)) idx = idx + 3'd1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/board_renderer_if.sv
// Pixel-side bundle between timing generator, game logic and the renderer.
// slave = renderer view, master = driver view (timing generator / game logic / bench).
interface board_renderer_if;

  logic                 PIX_EN;
  logic [10:0]          X;
  logic [10:0]          Y;
  logic                 IN_HS;
  logic                 IN_VS;
  logic                 IN_BLANK_N;
  logic                 WR_EN;
  logic [2:0]           WR_ROW;
  logic [2:0]           WR_COL;
  board_pkg::cell_t     WR_DATA;
  logic                 COMMIT;
  logic                 COMMIT_DONE;
  logic [2:0]           CUR_ROW;
  logic [2:0]           CUR_COL;
  logic [7:0]           VGA_R;
  logic [7:0]           VGA_G;
  logic [7:0]           VGA_B;
  logic                 VGA_HS;
  logic                 VGA_VS;
  logic                 VGA_BLANK_N;

  modport slave (
    input  PIX_EN, X, Y, IN_HS, IN_VS, IN_BLANK_N,
    input  WR_EN, WR_ROW, WR_COL, WR_DATA, COMMIT, CUR_ROW, CUR_COL,
    output COMMIT_DONE, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
  );

  modport master (
    output PIX_EN, X, Y, IN_HS, IN_VS, IN_BLANK_N,
    output WR_EN, WR_ROW, WR_COL, WR_DATA, COMMIT, CUR_ROW, CUR_COL,
    input  COMMIT_DONE, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
  );

endinterface

// File: rtl/board_store.sv
// Double-buffered cell store: shadow written any cycle, copied whole to display on a VS fall.
// Read port is combinational; no backpressure, writes never stall.
module board_store
  import board_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pix_en,
  input  logic       i_vs,
  input  logic       i_wr_en,
  input  logic [2:0] i_wr_row,
  input  logic [2:0] i_wr_col,
  input  cell_t      i_wr_data,
  input  logic       i_commit,
  output logic       o_commit_done,
  input  logic [2:0] i_rd_row,
  input  logic [2:0] i_rd_col,
  output cell_t      o_rd_cell
);

  cell_t r_shadow  [BOARD_N][BOARD_N];
  cell_t r_display [BOARD_N][BOARD_N];
  logic  r_vs_q;
  logic  r_pending;
  logic  r_commit_done;

  logic  w_wr_ok;
  logic  w_vs_fall;
  logic  w_pending;

  assign w_wr_ok   = i_wr_en && ({1'b0, i_wr_row} < 4'(BOARD_N)) && ({1'b0, i_wr_col} < 4'(BOARD_N));
  assign w_vs_fall = i_pix_en && r_vs_q && !i_vs;
  assign w_pending = r_pending || i_commit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < BOARD_N; r++)
        for (int c = 0; c < BOARD_N; c++)
          r_shadow[r][c] <= EMPTY;
    end else if (w_wr_ok) begin
      r_shadow[i_wr_row][i_wr_col] <= i_wr_data;
    end
  end

  // The copy reads r_shadow before this edge's write lands, so a same-cycle write waits for the next publish.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs_q        <= 1'b1;
      r_pending     <= 1'b0;
      r_commit_done <= 1'b0;
      for (int r = 0; r < BOARD_N; r++)
        for (int c = 0; c < BOARD_N; c++)
          r_display[r][c] <= EMPTY;
    end else begin
      if (i_pix_en) r_vs_q <= i_vs;
      if (w_vs_fall && w_pending) begin
        r_display     <= r_shadow;
        r_pending     <= 1'b0;
        r_commit_done <= 1'b1;
      end else begin
        r_pending     <= w_pending;
        r_commit_done <= 1'b0;
      end
    end
  end

  assign o_commit_done = r_commit_done;
  assign o_rd_cell     = r_display[i_rd_row][i_rd_col];

endmodule

// File: rtl/board_renderer.sv
// 8x8 board pixel pipeline: 3 PIX_EN stages from X/Y to RGB, strobes delay-matched; stalls when PIX_EN=0.
// Optional cursor outline when BOARD_CURSOR_EN is defined.
module board_renderer
  import board_pkg::*;
(
  input  logic              CLK_50,
  input  logic              RST_N,
  board_renderer_if.slave   bus
);

  localparam logic [10:0] X_END = 11'(BOARD_X0 + BOARD_N * CELL_PX);
  localparam logic [10:0] Y_END = 11'(BOARD_Y0 + BOARD_N * CELL_PX);
  localparam logic [5:0]  O_MAX = 6'(CELL_PX - 1);

  // Stage 1: inside test, cell index, in-cell offset
  logic       w_inside;
  logic [2:0] w_col, w_row;
  logic [5:0] w_ox, w_oy;

  assign w_inside = (bus.X >= 11'(BOARD_X0)) && (bus.X < X_END) &&
                    (bus.Y >= 11'(BOARD_Y0)) && (bus.Y < Y_END);
  assign w_col = cell_index(bus.X, 11'(BOARD_X0));
  assign w_row = cell_index(bus.Y, 11'(BOARD_Y0));
  assign w_ox  = 6'(bus.X - 11'(BOARD_X0) - 11'(32'(w_col) * CELL_PX));
  assign w_oy  = 6'(bus.Y - 11'(BOARD_Y0) - 11'(32'(w_row) * CELL_PX));

  logic       r_s1_inside;
  logic [2:0] r_s1_row, r_s1_col;
  logic [5:0] r_s1_ox, r_s1_oy;

  // Stage 2: cell lookup, disc distance, grid and cursor hit
  cell_t              w_cell;
  logic signed [6:0]  w_dx, w_dy;
  logic signed [12:0] w_dx_e, w_dy_e, w_d2_s;
  logic [12:0]        w_d2;
  logic               w_grid, w_disc, w_cur;

  board_store u_store (
    .i_clk         (CLK_50),
    .i_rst_n       (RST_N),
    .i_pix_en      (bus.PIX_EN),
    .i_vs          (bus.IN_VS),
    .i_wr_en       (bus.WR_EN),
    .i_wr_row      (bus.WR_ROW),
    .i_wr_col      (bus.WR_COL),
    .i_wr_data     (bus.WR_DATA),
    .i_commit      (bus.COMMIT),
    .o_commit_done (bus.COMMIT_DONE),
    .i_rd_row      (r_s1_row),
    .i_rd_col      (r_s1_col),
    .o_rd_cell     (w_cell)
  );

  assign w_dx   = $signed({1'b0, r_s1_ox}) - $signed(7'(CELL_PX / 2));
  assign w_dy   = $signed({1'b0, r_s1_oy}) - $signed(7'(CELL_PX / 2));
  assign w_dx_e = {{6{w_dx[6]}}, w_dx};
  assign w_dy_e = {{6{w_dy[6]}}, w_dy};
  assign w_d2_s = w_dx_e * w_dx_e + w_dy_e * w_dy_e;
  assign w_d2   = unsigned'(w_d2_s);
  assign w_disc = w_d2 < 13'(DISC_R * DISC_R);
  assign w_grid = (r_s1_ox == 6'd0) || (r_s1_oy == 6'd0) || (r_s1_ox == O_MAX) || (r_s1_oy == O_MAX);

`ifdef BOARD_CURSOR_EN
  logic w_ring, w_band_x, w_band_y;
  assign w_ring   = (r_s1_ox >= 6'd1) && (r_s1_ox <= 6'(CELL_PX - 2)) &&
                    (r_s1_oy >= 6'd1) && (r_s1_oy <= 6'(CELL_PX - 2));
  assign w_band_x = (r_s1_ox <= 6'd2) || (r_s1_ox >= 6'(CELL_PX - 3));
  assign w_band_y = (r_s1_oy <= 6'd2) || (r_s1_oy >= 6'(CELL_PX - 3));
  assign w_cur    = (r_s1_row == bus.CUR_ROW) && (r_s1_col == bus.CUR_COL) &&
                    w_ring && (w_band_x || w_band_y);
`else
  logic w_unused_cur;
  assign w_unused_cur = ^{bus.CUR_ROW, bus.CUR_COL};
  assign w_cur        = 1'b0;
`endif

  logic  r_s2_inside, r_s2_grid, r_s2_cur, r_s2_disc;
  cell_t r_s2_cell;

  // Strobe delay lines, index PIPE_DEPTH-1 is the output tap
  logic [PIPE_DEPTH-1:0] r_hs, r_vs, r_blank;

  // Stage 3: colour priority, then blank override from the strobe aligned with this stage
  rgb_t w_rgb;
  rgb_t r_rgb;

  always_comb begin
    w_rgb = BOARD_C;
    if (!r_s2_inside)   w_rgb = BG;
    else if (r_s2_grid) w_rgb = LINE;
    else if (r_s2_cur)  w_rgb = CURSOR;
    else if (r_s2_disc) begin
      case (r_s2_cell)
        P1:      w_rgb = P1_C;
        P2:      w_rgb = P2_C;
        MARK:    w_rgb = MARK_C;
        default: w_rgb = BOARD_C;
      endcase
    end
    if (!r_blank[PIPE_DEPTH-2]) w_rgb = '0;
  end

  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_s1_inside <= 1'b0;
      r_s1_row    <= '0;
      r_s1_col    <= '0;
      r_s1_ox     <= '0;
      r_s1_oy     <= '0;
      r_s2_inside <= 1'b0;
      r_s2_grid   <= 1'b0;
      r_s2_cur    <= 1'b0;
      r_s2_disc   <= 1'b0;
      r_s2_cell   <= EMPTY;
      r_rgb       <= '0;
      r_hs        <= '1;
      r_vs        <= '1;
      r_blank     <= '0;
    end else if (bus.PIX_EN) begin
      r_s1_inside <= w_inside;
      r_s1_row    <= w_row;
      r_s1_col    <= w_col;
      r_s1_ox     <= w_ox;
      r_s1_oy     <= w_oy;
      r_s2_inside <= r_s1_inside;
      r_s2_grid   <= w_grid;
      r_s2_cur    <= w_cur;
      r_s2_disc   <= w_disc;
      r_s2_cell   <= w_cell;
      r_rgb       <= w_rgb;
      r_hs        <= {r_hs[PIPE_DEPTH-2:0], bus.IN_HS};
      r_vs        <= {r_vs[PIPE_DEPTH-2:0], bus.IN_VS};
      r_blank     <= {r_blank[PIPE_DEPTH-2:0], bus.IN_BLANK_N};
    end
  end

  assign bus.VGA_R       = r_rgb.r;
  assign bus.VGA_G       = r_rgb.g;
  assign bus.VGA_B       = r_rgb.b;
  assign bus.VGA_HS      = r_hs[PIPE_DEPTH-1];
  assign bus.VGA_VS      = r_vs[PIPE_DEPTH-1];
  assign bus.VGA_BLANK_N = r_blank[PIPE_DEPTH-1];

endmodule
